// File: rtl/cve2_dotp_ctrl_if.sv
// Bundle of the ID/EX-side and MAC-side signals of the packed 4x8 dot-product sequencer.
// Handshake: the ID stage holds en_i && sel_i to launch an op sampled in IDLE; the result is
// offered with valid_o and stays stable until the cycle in which ready_id_i is high, which retires it.
interface cve2_dotp_ctrl_if;
  logic        en_i;
  logic        sel_i;
  logic [1:0]  signed_mode_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] acc_i;
  logic        ready_id_i;
  logic [31:0] mac_result_i;

  logic        mac_req_o;
  logic [31:0] mac_op_a_o;
  logic [31:0] mac_op_b_o;
  logic [31:0] mac_acc_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic        busy_o;
  logic [1:0]  state_o;

  modport slave (
    input  en_i, sel_i, signed_mode_i, op_a_i, op_b_i, acc_i, ready_id_i, mac_result_i,
    output mac_req_o, mac_op_a_o, mac_op_b_o, mac_acc_o, valid_o, result_o, busy_o, state_o
  );

  modport master (
    output en_i, sel_i, signed_mode_i, op_a_i, op_b_i, acc_i, ready_id_i, mac_result_i,
    input  mac_req_o, mac_op_a_o, mac_op_b_o, mac_acc_o, valid_o, result_o, busy_o, state_o
  );
endinterface

// File: rtl/cve2_dotp_ctrl.sv
// Sequencer that feeds one byte lane per cycle into the shared EX-stage MAC to compute
// acc + sum(a[i]*b[i]) mod 2^32, skipping zero lanes when ZeroSkip is set.
module cve2_dotp_ctrl #(
  parameter bit ZeroSkip = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cve2_dotp_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [3:0]  mask_q;
  logic [31:0] acc_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  mode_q;

  logic [3:0]  mask_d;
  logic [3:0]  mask_rem;
  logic [7:0]  byte_a;
  logic [7:0]  byte_b;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if      (m[0]) idx = 2'd0;
    else if (m[1]) idx = 2'd1;
    else if (m[2]) idx = 2'd2;
    else if (m[3]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    logic [7:0] b;
    case (l)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  always_comb begin
    mask_d = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (ZeroSkip) mask_d[i] = (|bus.op_a_i[8*i +: 8]) && (|bus.op_b_i[8*i +: 8]);
    end
  end

  // Lanes are issued in ascending order, so the lowest remaining bit is the next lane above.
  assign mask_rem = mask_q & ~(4'b0001 << lane_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      mask_q  <= 4'd0;
      acc_q   <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      mode_q  <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en_i && bus.sel_i) begin
            a_q     <= bus.op_a_i;
            b_q     <= bus.op_b_i;
            mode_q  <= bus.signed_mode_i;
            mask_q  <= mask_d;
            acc_q   <= bus.acc_i;
            lane_q  <= lowest_set(mask_d);
            state_q <= (mask_d != 4'd0) ? CALC : DONE;
          end
        end
        CALC: begin
          if (!bus.en_i) begin
            state_q <= IDLE;
          end else begin
            acc_q  <= bus.mac_result_i;
            mask_q <= mask_rem;
            if (mask_rem != 4'd0) lane_q  <= lowest_set(mask_rem);
            else                  state_q <= DONE;
          end
        end
        DONE: begin
          if (!bus.en_i || bus.ready_id_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_a = lane_byte(a_q, lane_q);
  assign byte_b = lane_byte(b_q, lane_q);

  always_comb begin
    bus.mac_req_o  = 1'b0;
    bus.mac_op_a_o = 32'd0;
    bus.mac_op_b_o = 32'd0;
    bus.mac_acc_o  = 32'd0;
    bus.valid_o    = 1'b0;
    bus.result_o   = 32'd0;
    if (state_q == CALC) begin
      bus.mac_req_o  = 1'b1;
      bus.mac_op_a_o = {{24{mode_q[0] & byte_a[7]}}, byte_a};
      bus.mac_op_b_o = {{24{mode_q[1] & byte_b[7]}}, byte_b};
      bus.mac_acc_o  = acc_q;
    end
    if (state_q == DONE) begin
      bus.valid_o  = 1'b1;
      bus.result_o = acc_q;
    end
  end

  assign bus.busy_o  = (state_q != IDLE);
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_cve2_dotp_ctrl.sv
// Directed bench for the dot-product sequencer: one instance without and one with zero skipping,
// each closed around a behavioural MAC.
module tb_cve2_dotp_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cve2_dotp_ctrl_if bus0();
  cve2_dotp_ctrl_if bus1();

  cve2_dotp_ctrl #(.ZeroSkip(1'b0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  cve2_dotp_ctrl #(.ZeroSkip(1'b1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  assign bus0.mac_result_i = bus0.mac_acc_o + bus0.mac_op_a_o * bus0.mac_op_b_o;
  assign bus1.mac_result_i = bus1.mac_acc_o + bus1.mac_op_a_o * bus1.mac_op_b_o;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus0.en_i = 0; bus0.sel_i = 0; bus0.ready_id_i = 0; bus0.signed_mode_i = 0;
    bus0.op_a_i = 0; bus0.op_b_i = 0; bus0.acc_i = 0;
    bus1.en_i = 0; bus1.sel_i = 0; bus1.ready_id_i = 0; bus1.signed_mode_i = 0;
    bus1.op_a_i = 0; bus1.op_b_i = 0; bus1.acc_i = 0;
  endtask

  // Presents the op in cycle T on bus0; returns just after the capturing edge.
  task automatic start0(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                        input logic [1:0] mode);
    @(posedge clk); #1;
    bus0.op_a_i = a; bus0.op_b_i = b; bus0.acc_i = acc; bus0.signed_mode_i = mode;
    bus0.en_i = 1; bus0.sel_i = 1; bus0.ready_id_i = 0;
    @(posedge clk); #1;
    bus0.sel_i = 0;
  endtask

  // Runs a whole op on bus1: latency in cycles after T, number of MAC-request cycles, result.
  task automatic op1(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                     input logic [1:0] mode, output int lat, output int reqs,
                     output logic [31:0] res);
    @(posedge clk); #1;
    bus1.op_a_i = a; bus1.op_b_i = b; bus1.acc_i = acc; bus1.signed_mode_i = mode;
    bus1.en_i = 1; bus1.sel_i = 1; bus1.ready_id_i = 0;
    @(posedge clk); #1;
    bus1.sel_i = 0;
    lat = -1; reqs = 0; res = 32'hDEADBEEF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus1.mac_req_o) reqs++;
      if (bus1.valid_o) begin
        lat = c; res = bus1.result_o;
        break;
      end
    end
    @(posedge clk); #1;
    bus1.ready_id_i = 1;
    @(posedge clk); #1;
    bus1.ready_id_i = 0; bus1.en_i = 0;
  endtask

  // Runs scenario 1 on bus0 to completion and returns the result (or -1 latency on timeout).
  task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                     input logic [1:0] mode, output int lat, output logic [31:0] res);
    start0(a, b, acc, mode);
    lat = -1; res = 32'hDEADBEEF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus0.valid_o) begin
        lat = c; res = bus0.result_o;
        break;
      end
    end
    @(posedge clk); #1;
    bus0.ready_id_i = 1;
    @(posedge clk); #1;
    bus0.ready_id_i = 0; bus0.en_i = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    n_checks++;
    if ({bus0.mac_req_o, bus0.valid_o, bus0.busy_o, bus1.mac_req_o, bus1.valid_o, bus1.busy_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
        {bus0.mac_req_o, bus0.valid_o, bus0.busy_o, bus1.mac_req_o, bus1.valid_o, bus1.busy_o});
    end
    n_checks++;
    if ((bus0.result_o | bus0.mac_acc_o | bus0.mac_op_a_o | bus0.mac_op_b_o | bus1.result_o) !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00000000",
        bus0.result_o | bus0.mac_acc_o | bus0.mac_op_a_o | bus0.mac_op_b_o | bus1.result_o);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (bus0.state_o !== 2'd0 || bus1.state_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d/%0d expected 0/0", bus0.state_o, bus1.state_o);
    end
  endtask

  task automatic test_sel_gating();
    @(posedge clk); #1;
    bus1.en_i = 1; bus1.sel_i = 0; bus1.op_a_i = 32'h01010101; bus1.op_b_i = 32'h01010101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus1.busy_o !== 1'b0) begin
        n_fail++; $display("FAIL sel_gating: busy got %b expected 0 (cycle %0d)", bus1.busy_o, i);
      end
    end
    @(posedge clk); #1;
    bus1.en_i = 0;
  endtask

  task automatic test_unsigned_noskip();
    logic [31:0] exp_acc;
    start0(32'h04030201, 32'h01010101, 32'd10, 2'b00);
    exp_acc = 32'd10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.mac_req_o !== 1'b1 || bus0.valid_o !== 1'b0 || bus0.busy_o !== 1'b1) begin
        n_fail++; $display("FAIL calc_flags lane %0d: req/valid/busy got %b%b%b expected 101",
          i, bus0.mac_req_o, bus0.valid_o, bus0.busy_o);
      end
      n_checks++;
      if (bus0.mac_op_a_o !== 32'(i + 1) || bus0.mac_op_b_o !== 32'd1 || bus0.mac_acc_o !== exp_acc) begin
        n_fail++; $display("FAIL calc_ops lane %0d: got a=%h b=%h acc=%h expected a=%h b=1 acc=%h",
          i, bus0.mac_op_a_o, bus0.mac_op_b_o, bus0.mac_acc_o, 32'(i + 1), exp_acc);
      end
      exp_acc = exp_acc + 32'(i + 1);
    end
    // T+5..T+7 with ready held low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.valid_o !== 1'b1 || bus0.result_o !== 32'd20 || bus0.mac_req_o !== 1'b0) begin
        n_fail++; $display("FAIL done_hold cycle %0d: valid=%b result=%0d req=%b expected 1/20/0",
          i, bus0.valid_o, bus0.result_o, bus0.mac_req_o);
      end
    end
    @(posedge clk); #1;
    bus0.ready_id_i = 1;
    @(posedge clk); #1;
    bus0.ready_id_i = 0; bus0.en_i = 0;
    @(negedge clk);
    n_checks++;
    if (bus0.busy_o !== 1'b0 || bus0.valid_o !== 1'b0 || bus0.result_o !== 32'd0) begin
      n_fail++; $display("FAIL retire: busy=%b valid=%b result=%h expected 0/0/0",
        bus0.busy_o, bus0.valid_o, bus0.result_o);
    end
  endtask

  task automatic test_signed();
    int lat, reqs;
    logic [31:0] res;
    op1(32'hFFFFFFFF, 32'h02020202, 32'd0, 2'b11, lat, reqs, res);
    n_checks++;
    if (res !== 32'hFFFFFFF8 || lat != 5 || reqs != 4) begin
      n_fail++; $display("FAIL signed_11: got res=%h lat=%0d reqs=%0d expected FFFFFFF8/5/4", res, lat, reqs);
    end
    op1(32'hFFFFFFFF, 32'h02020202, 32'd0, 2'b00, lat, reqs, res);
    n_checks++;
    if (res !== 32'h000007F8 || lat != 5) begin
      n_fail++; $display("FAIL signed_00: got res=%h lat=%0d expected 000007F8/5", res, lat);
    end
  endtask

  task automatic test_mixed_skip();
    int lat, reqs;
    logic [31:0] res;
    op1(32'h00000080, 32'h000000FF, 32'd0, 2'b01, lat, reqs, res);
    n_checks++;
    if (res !== 32'hFFFF8080 || lat != 2 || reqs != 1) begin
      n_fail++; $display("FAIL mixed_skip: got res=%h lat=%0d reqs=%0d expected FFFF8080/2/1", res, lat, reqs);
    end
    op1(32'h05000300, 32'h02000400, 32'd1, 2'b00, lat, reqs, res);
    n_checks++;
    if (res !== 32'd23 || lat != 3 || reqs != 2) begin
      n_fail++; $display("FAIL sparse_lanes: got res=%0d lat=%0d reqs=%0d expected 23/3/2", res, lat, reqs);
    end
  endtask

  task automatic test_zero_mask();
    int lat, reqs;
    logic [31:0] res;
    op1(32'h00000000, 32'h11223344, 32'h12345678, 2'b00, lat, reqs, res);
    n_checks++;
    if (res !== 32'h12345678 || lat != 1 || reqs != 0) begin
      n_fail++; $display("FAIL zero_mask: got res=%h lat=%0d reqs=%0d expected 12345678/1/0", res, lat, reqs);
    end
  endtask

  task automatic test_wrap();
    int lat, reqs;
    logic [31:0] res;
    op1(32'h00000001, 32'h00000001, 32'hFFFFFFFF, 2'b00, lat, reqs, res);
    n_checks++;
    if (res !== 32'h00000000 || lat != 2) begin
      n_fail++; $display("FAIL wrap: got res=%h lat=%0d expected 00000000/2", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus1.op_a_i = 32'h1; bus1.op_b_i = 32'h1; bus1.acc_i = 32'hFFFFFFFF; bus1.signed_mode_i = 2'b00;
    bus1.en_i = 1; bus1.sel_i = 1; bus1.ready_id_i = 1;
    @(posedge clk); #1;
    bus1.acc_i = 32'd5;
    @(negedge clk); // T+1 CALC
    @(negedge clk); // T+2 DONE, retired by ready
    n_checks++;
    if (bus1.valid_o !== 1'b1 || bus1.result_o !== 32'd0) begin
      n_fail++; $display("FAIL b2b_first: valid=%b result=%h expected 1/00000000", bus1.valid_o, bus1.result_o);
    end
    @(negedge clk); // T+3 must be IDLE
    n_checks++;
    if (bus1.busy_o !== 1'b0 || bus1.state_o !== 2'd0) begin
      n_fail++; $display("FAIL b2b_idle_gap: busy=%b state=%0d expected 0/0", bus1.busy_o, bus1.state_o);
    end
    @(negedge clk); // T+4 relaunched
    n_checks++;
    if (bus1.mac_req_o !== 1'b1 || bus1.mac_acc_o !== 32'd5) begin
      n_fail++; $display("FAIL b2b_relaunch: req=%b acc=%h expected 1/00000005", bus1.mac_req_o, bus1.mac_acc_o);
    end
    bus1.sel_i = 0;
    @(negedge clk);
    n_checks++;
    if (bus1.valid_o !== 1'b1 || bus1.result_o !== 32'd6) begin
      n_fail++; $display("FAIL b2b_second: valid=%b result=%0d expected 1/6", bus1.valid_o, bus1.result_o);
    end
    @(posedge clk); #1;
    bus1.en_i = 0; bus1.ready_id_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int n_valid;
    int lat;
    logic [31:0] res;
    start0(32'h04030201, 32'h01010101, 32'd10, 2'b00);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus0.mac_req_o !== 1'b1 || bus0.mac_acc_o !== 32'd11) begin
      n_fail++; $display("FAIL abort_pre: req=%b acc=%0d expected 1/11", bus0.mac_req_o, bus0.mac_acc_o);
    end
    @(posedge clk); #1;
    bus0.en_i = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus0.busy_o !== 1'b0 || bus0.mac_req_o !== 1'b0 || bus0.result_o !== 32'd0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b req=%b result=%h expected 0/0/0",
        bus0.busy_o, bus0.mac_req_o, bus0.result_o);
    end
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus0.valid_o) n_valid++;
    end
    n_checks++;
    if (n_valid != 0) begin
      n_fail++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", n_valid);
    end
    op0(32'h04030201, 32'h01010101, 32'd10, 2'b00, lat, res);
    n_checks++;
    if (res !== 32'd20 || lat != 5) begin
      n_fail++; $display("FAIL abort_rerun: got res=%0d lat=%0d expected 20/5", res, lat);
    end
  endtask

  task automatic test_reset_mid_calc();
    start0(32'h04030201, 32'h01010101, 32'd10, 2'b00);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({bus0.mac_req_o, bus0.busy_o, bus0.valid_o} !== 3'b000 ||
        (bus0.mac_op_a_o | bus0.mac_op_b_o | bus0.mac_acc_o | bus0.result_o) !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_calc: req=%b busy=%b valid=%b a=%h b=%h acc=%h expected all 0",
        bus0.mac_req_o, bus0.busy_o, bus0.valid_o, bus0.mac_op_a_o, bus0.mac_op_b_o, bus0.mac_acc_o);
    end
    bus0.en_i = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (bus0.state_o !== 2'd0 || bus0.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: state=%0d busy=%b expected 0/0", bus0.state_o, bus0.busy_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sel_gating();
    test_unsigned_noskip();
    test_signed();
    test_mixed_skip();
    test_zero_mask();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cve2_dotp_ctrl.md
# cve2_dotp_ctrl

Multi-cycle sequencer that runs a packed 4×8-bit dot-product-accumulate (result = acc + Σ a[i]·b[i]) through the EX-stage MAC unit (acc + a·b, low 32 bits). It sits in the EX block beside the multiplier/divider. It uses the same dynamic-enable / valid / ready-from-ID handshake. While `mac_req_o` is high it owns the MAC operand inputs, and it feeds one lane per cycle, holding the running sum in an internal register.

## Interface
- `ZeroSkip`, default 1: when 1, lanes where either operand byte is zero are not issued to the MAC.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `en_i`  in  1  dynamic enable from the ID FSM. Deassertion aborts the operation.
- `sel_i`  in  1  static decoder select for the dot-product instruction.
- `signed_mode_i`  in  2  bit0 = operand-A bytes signed, bit1 = operand-B bytes signed.
- `op_a_i`  in  32  packed bytes A, lane i = bits [8i+7:8i].
- `op_b_i`  in  32  packed bytes B.
- `acc_i`  in  32  initial accumulator value (rd read value).
- `ready_id_i`  in  1  ID stage accepts the result.
- `mac_result_i`  in  32  MAC output: `mac_acc_o` + `mac_op_a_o`·`mac_op_b_o`, mod 2^32.
- `mac_req_o`  out  1  controller drives the MAC operands this cycle. The EX mux selects on this.
- `mac_op_a_o`  out  32  extended byte A of the current lane; 0 when not requesting.
- `mac_op_b_o`  out  32  extended byte B of the current lane; 0 when not requesting.
- `mac_acc_o`  out  32  running sum; 0 when not requesting.
- `valid_o`  out  1  result valid.
- `result_o`  out  32  final sum. Equals the accumulator register in DONE, 0 otherwise.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CALC, DONE. Registers:
  - `state_q`
  - `lane_q[1:0]`
  - `mask_q[3:0]`
  - `acc_q[31:0]`
  - `a_q`, `b_q[31:0]`
  - `mode_q[1:0]`
- Lane mask:
  - Bit i = (a[i]≠0 && b[i]≠0) if `ZeroSkip`.
  - Otherwise all ones.
- IDLE, when `en_i && sel_i`:
  - Latch operands, mode and mask.
  - Set `acc_q` ← `acc_i`.
  - Set `lane_q` ← lowest set mask bit.
  - Go to CALC if mask≠0, else DONE.
- CALC:
  - Assert `mac_req_o`.
  - `mac_op_a_o` = byte `a_q[lane_q]`, sign-extended if `mode_q[0]`, else zero-extended. `mac_op_b_o` is the same using `mode_q[1]`.
  - `mac_acc_o` = `acc_q`.
  - At the clock edge: `acc_q` ← `mac_result_i` and clear `mask_q[lane_q]`.
  - If mask bits remain, `lane_q` ← next set bit above `lane_q`. Otherwise go to DONE.
- DONE: `valid_o` = 1, `result_o` = `acc_q`. If `ready_id_i`, go to IDLE. Otherwise hold; `valid_o` and `result_o` stay stable.
- Abort: `en_i` = 0 in CALC or DONE → IDLE at the next edge. No valid is produced and `acc_q` is not exported.
- `en_i && sel_i` in CALC or DONE: no relatch. Operands are sampled only in IDLE.
- `sel_i` = 0 with `en_i` = 1 in IDLE: stay in IDLE.
- Arithmetic: all sums wrap mod 2^32. There is no saturation and no overflow flag.
- DONE followed by a new op: IDLE must be visited for at least one cycle (no back-to-back from DONE).

## Timing
- Reset values:
  - State IDLE.
  - All registers 0.
  - `valid_o`, `mac_req_o`, `busy_o` = 0.
  - `mac_op_*_o`, `mac_acc_o`, `result_o` = 0.
- Latency from the cycle T in which IDLE sees `en_i && sel_i`:
  - CALC occupies T+1 … T+k, where k = popcount(mask) (k = 4 if `ZeroSkip` = 0).
  - `valid_o` first high at T+k+1.
  - All-zero mask: `valid_o` at T+1, and `mac_req_o` is never asserted.
- `busy_o` is high from T+1 until the cycle after the ready or abort edge.
- MAC path is combinational within one CALC cycle, and `mac_result_i` is sampled at the end of that cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously), and the state is IDLE on release.

## Test plan
- Unsigned, `ZeroSkip` = 0:
  - Stimulus: a = 0x04030201, b = 0x01010101, acc = 10, mode = 00.
  - `mac_req_o` high for 4 cycles, lanes 0→3.
  - `valid_o` at T+5, result = 20. Hold `ready_id_i` = 0 for 3 cycles: result stays stable.
- Signed:
  - Stimulus: a = 0xFFFFFFFF, b = 0x02020202, acc = 0, mode = 11.
  - Result = 0xFFFFFFF8. With mode = 00, result = 0x000007F8.
- Mixed sign, `ZeroSkip` = 1:
  - Stimulus: a = 0x00000080, b = 0x000000FF, acc = 0, mode = 01.
  - Exactly one CALC cycle (lane 0), `valid_o` at T+2, result = 0xFFFF8080.
- Zero skip, all-zero mask:
  - Stimulus: a = 0, b = 0x11223344, acc = 0x12345678.
  - `valid_o` at T+1, result = 0x12345678, `mac_req_o` never high.
- Wrap-around:
  - Stimulus: acc = 0xFFFFFFFF, a = 0x00000001, b = 0x00000001, mode = 00.
  - Result = 0x00000000.
- Abort and reset:
  - Drop `en_i` after 2 CALC cycles of scenario 1: IDLE next cycle, `valid_o` never high.
  - Rerun scenario 1 with no disturbance: result = 20, uncontaminated.
  - Assert `rst_ni` mid-CALC: outputs go to 0 immediately.
